uart_frame_assembler: RTL and testbench

//  Sits between uart_top's received-byte output and the coprocessor din/din_valid input.

---
 rtl/uart_frame_assembler_if.sv | 27 ++
 rtl/uart_frame_assembler.sv | 106 ++++++++++
 tb/tb_uart_frame_assembler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_frame_assembler_if.sv
// Byte-in / frame-out handshake bundle for uart_frame_assembler.
// slave is the assembler side; master is the byte producer / frame consumer side.
interface uart_frame_assembler_if #(
    parameter int DBITS       = 8,
    parameter int FRAME_BYTES = 8
);
    logic [DBITS-1:0]               byte_in;
    logic                           byte_valid;
    logic                           clear_flags;
    logic [FRAME_BYTES*DBITS-1:0]   frame_out;
    logic                           frame_valid;
    logic                           frame_ready;
    logic [$clog2(FRAME_BYTES+1)-1:0] byte_count;
    logic                           busy;
    logic                           overrun;
    logic                           timeout_seen;

    modport slave (
        input  byte_in, byte_valid, clear_flags, frame_ready,
        output frame_out, frame_valid, byte_count, busy, overrun, timeout_seen
    );

    modport master (
        output byte_in, byte_valid, clear_flags, frame_ready,
        input  frame_out, frame_valid, byte_count, busy, overrun, timeout_seen
    );
endinterface

// File: rtl/uart_frame_assembler.sv
// Packs FRAME_BYTES consecutive UART bytes into one frame with a valid/ready
// handshake; partial frames are dropped after an inter-byte timeout.
module uart_frame_assembler #(
    parameter int DBITS          = 8,
    parameter int FRAME_BYTES    = 8,
    parameter int TIMEOUT_CYCLES = 1_033_400
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_frame_assembler_if.slave    bus
);
    localparam int FW = FRAME_BYTES * DBITS;
    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(FRAME_BYTES - 1);
    localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT_CYCLES - 1);
    localparam logic          ONE_BYTE  = (FRAME_BYTES == 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t          state;
    logic [FW-1:0]   frame_q;
    logic [CW-1:0]   count_q;
    logic [TW-1:0]   timer_q;
    logic            valid_q;
    logic            overrun_q;
    logic            timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_q   <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // Flag sets below come later and therefore win over the clear.
            if (bus.clear_flags) begin
                overrun_q <= 1'b0;
                timeout_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.byte_valid) begin
                        frame_q <= FW'(bus.byte_in);
                        count_q <= CW'(1);
                        timer_q <= '0;
                        state   <= ONE_BYTE ? HOLD : COLLECT;
                        valid_q <= ONE_BYTE;
                    end
                end
                COLLECT: begin
                    if (bus.byte_valid) begin
                        for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
                            if (count_q == CW'(i))
                                frame_q[i*DBITS +: DBITS] <= bus.byte_in;
                        end
                        count_q <= count_q + CW'(1);
                        timer_q <= '0;
                        if (count_q == LAST_SLOT) begin
                            state   <= HOLD;
                            valid_q <= 1'b1;
                        end
                    end else if (timer_q == TIMER_END) begin
                        count_q   <= '0;
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                HOLD: begin
                    if (bus.frame_ready) begin
                        if (bus.byte_valid) begin
                            // Handshake and new byte together: byte starts the next frame.
                            frame_q <= FW'(bus.byte_in);
                            count_q <= CW'(1);
                            timer_q <= '0;
                            state   <= ONE_BYTE ? HOLD : COLLECT;
                            valid_q <= ONE_BYTE;
                        end else begin
                            count_q <= '0;
                            state   <= IDLE;
                            valid_q <= 1'b0;
                        end
                    end else if (bus.byte_valid) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.frame_out    = frame_q;
    assign bus.frame_valid  = valid_q;
    assign bus.byte_count   = count_q;
    assign bus.busy         = (state != IDLE);
    assign bus.overrun      = overrun_q;
    assign bus.timeout_seen = timeout_q;
endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler with hand-computed expectations.
module tb_uart_frame_assembler;
    localparam int DBITS = 8;
    localparam int FB    = 8;
    localparam int TO    = 100;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    uart_frame_assembler_if #(.DBITS(DBITS), .FRAME_BYTES(FB)) ifc ();

    uart_frame_assembler #(
        .DBITS(DBITS),
        .FRAME_BYTES(FB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        ifc.byte_in    = b;
        ifc.byte_valid = 1'b1;
        tick();
        ifc.byte_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        ifc.byte_in = '0;
        ifc.byte_valid = 1'b0;
        ifc.clear_flags = 1'b0;
        ifc.frame_ready = 1'b0;
        repeat (3) tick();

        chk("rst_frame_out", ifc.frame_out, 64'h0);
        chk("rst_frame_valid", 64'(ifc.frame_valid), 64'h0);
        chk("rst_byte_count", 64'(ifc.byte_count), 64'h0);
        chk("rst_busy", 64'(ifc.busy), 64'h0);
        chk("rst_overrun", 64'(ifc.overrun), 64'h0);
        chk("rst_timeout", 64'(ifc.timeout_seen), 64'h0);
        rst_n = 1'b1;
        tick();

        // 1: spaced bytes, consumer always ready
        ifc.frame_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            send_byte(8'(i));
            chk("t1_count", 64'(ifc.byte_count), 64'(i));
            repeat (15) tick();
        end
        send_byte(8'h08);
        chk("t1_valid", 64'(ifc.frame_valid), 64'h1);
        chk("t1_frame", ifc.frame_out, 64'h0807060504030201);
        tick();
        chk("t1_valid_drop", 64'(ifc.frame_valid), 64'h0);
        chk("t1_idle", 64'(ifc.busy), 64'h0);
        chk("t1_count_zero", 64'(ifc.byte_count), 64'h0);

        // 2: back-to-back bytes, consumer stalled
        ifc.frame_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'hAA);
        chk("t2_valid", 64'(ifc.frame_valid), 64'h1);
        repeat (50) tick();
        chk("t2_valid_held", 64'(ifc.frame_valid), 64'h1);
        chk("t2_frame", ifc.frame_out, 64'hAAAAAAAAAAAAAAAA);

        // 3: byte while holding -> overrun, frame unchanged
        send_byte(8'h55);
        chk("t3_overrun", 64'(ifc.overrun), 64'h1);
        chk("t3_frame", ifc.frame_out, 64'hAAAAAAAAAAAAAAAA);
        chk("t3_count", 64'(ifc.byte_count), 64'd8);
        ifc.clear_flags = 1'b1;
        tick();
        ifc.clear_flags = 1'b0;
        chk("t3_clear", 64'(ifc.overrun), 64'h0);
        chk("t3_still_valid", 64'(ifc.frame_valid), 64'h1);
        ifc.frame_ready = 1'b1;
        tick();
        ifc.frame_ready = 1'b0;
        chk("t2_handshake_drop", 64'(ifc.frame_valid), 64'h0);
        chk("t2_count_zero", 64'(ifc.byte_count), 64'h0);

        // 4: partial frame times out after exactly TO idle cycles
        send_byte(8'hE1);
        send_byte(8'hE2);
        send_byte(8'hE3);
        chk("t4_count3", 64'(ifc.byte_count), 64'd3);
        repeat (TO - 1) tick();
        chk("t4_before_expiry", 64'(ifc.busy), 64'h1);
        chk("t4_no_timeout_yet", 64'(ifc.timeout_seen), 64'h0);
        tick();
        chk("t4_timeout", 64'(ifc.timeout_seen), 64'h1);
        chk("t4_count0", 64'(ifc.byte_count), 64'h0);
        chk("t4_idle", 64'(ifc.busy), 64'h0);
        chk("t4_no_valid", 64'(ifc.frame_valid), 64'h0);

        // byte arriving in the expiry cycle wins over the timeout
        ifc.clear_flags = 1'b1;
        tick();
        ifc.clear_flags = 1'b0;
        chk("t4_flag_cleared", 64'(ifc.timeout_seen), 64'h0);
        send_byte(8'hF0);
        repeat (TO - 1) tick();
        send_byte(8'hF1);
        chk("t4_race_count", 64'(ifc.byte_count), 64'd2);
        chk("t4_race_no_timeout", 64'(ifc.timeout_seen), 64'h0);
        repeat (TO) tick();
        chk("t4_race_later_timeout", 64'(ifc.timeout_seen), 64'h1);

        for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
        chk("t4_next_valid", 64'(ifc.frame_valid), 64'h1);
        chk("t4_next_frame", ifc.frame_out, 64'h1716151413121110);

        // 5: handshake coincides with a new byte
        ifc.byte_in = 8'h99;
        ifc.byte_valid = 1'b1;
        ifc.frame_ready = 1'b1;
        tick();
        ifc.byte_valid = 1'b0;
        ifc.frame_ready = 1'b0;
        chk("t5_valid_low", 64'(ifc.frame_valid), 64'h0);
        chk("t5_count1", 64'(ifc.byte_count), 64'd1);
        chk("t5_slot0", ifc.frame_out, 64'h99);
        chk("t5_no_overrun", 64'(ifc.overrun), 64'h0);
        chk("t5_busy", 64'(ifc.busy), 64'h1);

        // 6: asynchronous reset mid-frame
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i));
        chk("t6_count5", 64'(ifc.byte_count), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_frame", ifc.frame_out, 64'h0);
        chk("t6_rst_count", 64'(ifc.byte_count), 64'h0);
        chk("t6_rst_busy", 64'(ifc.busy), 64'h0);
        chk("t6_rst_timeout", 64'(ifc.timeout_seen), 64'h0);
        chk("t6_rst_valid", 64'(ifc.frame_valid), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send_byte(8'(8'h21 + i));
        chk("t6_valid", 64'(ifc.frame_valid), 64'h1);
        chk("t6_frame", ifc.frame_out, 64'h2827262524232221);
        ifc.frame_ready = 1'b1;
        tick();
        chk("t6_done", 64'(ifc.frame_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
